multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, and is the producer of the 3-bit ALUOp code consumed by the ALU control decoder.
- Waits on a memory ready handshake in memory-access states.

Parameters:
- STATE_WIDTH, 4, width of the encoded state register (14 states used).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- Opcode  input  6  instruction[31:26] from the instruction register
- MemReady  input  1  memory completed the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero (BEQ)
- IorD  output  1  0=PC, 1=ALUOut as memory address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  writeback source: 1=MDR, 0=ALUOut
- RegDst  output  1  1=rd, 0=rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=regA
- ALUSrcB  output  2  00=regB, 01=const 4, 10=imm, 11=imm<<2
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  output  3  111 R-type, 110 ADDI, 101 ORI, 100 add, 011 subtract
- IllegalOp  output  1  one-cycle pulse in DECODE on an unsupported opcode
- InstrDone  output  1  one-cycle pulse in an instruction's final state
- State  output  STATE_WIDTH  current state, for debug

Behaviour:
- Reset low: state=IDLE immediately. All outputs 0, including ALUOp=000.
- Outputs are decoded from state (Moore). Exception: IRWrite/PCWrite in FETCH and the MemReady-qualified transitions.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state FETCH on the first clk after reset release.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00.
  - MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
  - MemReady=0: stay in FETCH with no writes.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 001101 -> ORIEX
  - 000010 -> JUMP
  - other -> IllegalOp=1, FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until MemReady=1; in that cycle InstrDone=1, next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next ALUWB.
- ALUWB: RegDst=1, RegWrite=1, MemtoReg=0, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCWriteCond=1, PCSource=01, InstrDone=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=110. Next IMMWB.
- ORIEX: same as ADDIEX with ALUOp=101. Next IMMWB.
- IMMWB: RegDst=0, RegWrite=1, InstrDone=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next FETCH.
- Latency with MemReady held 1: R 4, LW 5, SW 4, BEQ 3, ADDI/ORI 4, J 3 cycles.
- Each MemReady low cycle adds exactly one cycle in FETCH/MEMRD/MEMWR. No timeout.
- MemReady outside memory states is ignored.
- Opcode is sampled only in DECODE and MEMADR. The IR is not written there, so it is stable.
- Reset asserted mid-instruction (any state, including a memory wait): immediate return to IDLE with all enables 0. No partial write is retried.
- Undefined state encodings recover to FETCH on the next clk.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined:
  - Adds output port PCWriteCondNe (1 bit) and state BRANCHNE.
  - DECODE with opcode 000101 -> BRANCHNE.
  - BRANCHNE matches BRANCH but asserts PCWriteCondNe=1 instead of PCWriteCond (PC load if Zero=0).
- Undefined:
  - Port and state are absent.
  - 000101 is treated as illegal (IllegalOp pulse, return to FETCH).

Decomposition:
- Shared package/header holds:
  - opcode localparams (R_TYPE, LW, SW, BEQ, BNE, ADDI, ORI, J)
  - ALUOp code localparams (ALUOP_RTYPE=111, ALUOP_ADDI=110, ALUOP_ORI=101, ALUOP_ADD=100, ALUOP_SUB=011)
  - state encodings
- The package is shared with the ALU control decoder so both ends agree on ALUOp codes.
- One natural sub-module: control_output_decode, a combinational state+MemReady to control-vector table.
- The next-state logic and state register stay in the top module.

Test Plan:
- Reset low 3 cycles, then release with MemReady=1 -> all outputs 0 during reset; FETCH at cycle 1 with IRWrite=1, PCWrite=1, ALUOp=100.
- Opcode 000000, MemReady=1 -> FETCH, DECODE, EXEC (ALUOp=111), ALUWB (RegWrite=1, RegDst=1, InstrDone=1); back in FETCH at cycle 5.
- Opcode 100011, MemReady low for 2 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1, IorD=1; then MEMWB with MemtoReg=1, RegWrite=1.
- Opcode 001101 then 001000 -> ORIEX shows ALUOp=101 and ADDIEX shows ALUOp=110; both reach IMMWB with RegDst=0.
- Opcode 000101 -> without CTRL_BNE_EN: IllegalOp=1 for 1 cycle, then FETCH. With CTRL_BNE_EN: BRANCHNE with PCWriteCondNe=1, ALUOp=011.
- Reset asserted while in MEMWR waiting (MemReady=0) -> MemWrite drops to 0 immediately; IDLE, then FETCH after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control FSM and the ALU control decoder.
// CTRL_BNE_EN adds the BRANCHNE state and makes the BNE opcode legal.
package multicycle_control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  // Instruction opcodes (instruction[31:26])
  localparam logic [OPCODE_W-1:0] R_TYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] LW     = 6'b100011;
  localparam logic [OPCODE_W-1:0] SW     = 6'b101011;
  localparam logic [OPCODE_W-1:0] BEQ    = 6'b000100;
  localparam logic [OPCODE_W-1:0] BNE    = 6'b000101;
  localparam logic [OPCODE_W-1:0] ADDI   = 6'b001000;
  localparam logic [OPCODE_W-1:0] ORI    = 6'b001101;
  localparam logic [OPCODE_W-1:0] J      = 6'b000010;

  // ALUOp codes; the ALU control decoder decodes these same values
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b111;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b011;

  localparam logic [SEL_W-1:0] SRCB_REGB     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    EXEC     = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ADDIEX   = 4'd10,
    ORIEX    = 4'd11,
    IMMWB    = 4'd12,
`ifdef CTRL_BNE_EN
    BRANCHNE = 4'd14,
`endif
    JUMP     = 4'd13
  } state_t;

  // Full datapath control vector for one cycle
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
`ifdef CTRL_BNE_EN
    logic               pc_write_cond_ne;
`endif
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal_op;
    logic               instr_done;
  } ctrl_t;

  function automatic logic opcode_supported(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = (op == R_TYPE) || (op == LW) || (op == SW) || (op == BEQ) ||
         (op == ADDI) || (op == ORI) || (op == J);
`ifdef CTRL_BNE_EN
    ok = ok || (op == BNE);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
// CTRL_BNE_EN adds PCWriteCondNe.
interface multicycle_control_if
  import multicycle_control_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = STATE_W
) ();

  logic [OPCODE_W-1:0]    Opcode;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   PCWriteCond;
`ifdef CTRL_BNE_EN
  logic                   PCWriteCondNe;
`endif
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [SEL_W-1:0]       ALUSrcB;
  logic [SEL_W-1:0]       PCSource;
  logic [ALUOP_W-1:0]     ALUOp;
  logic                   IllegalOp;
  logic                   InstrDone;
  logic [STATE_WIDTH-1:0] State;

  modport master (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond,
`ifdef CTRL_BNE_EN
    output PCWriteCondNe,
`endif
    output IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, InstrDone, State
  );

  modport slave (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond,
`ifdef CTRL_BNE_EN
    input  PCWriteCondNe,
`endif
    input  IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, InstrDone, State
  );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational state (+MemReady, +Opcode in DECODE) to control-vector table.
// CTRL_BNE_EN adds the BRANCHNE row.
module multicycle_control_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t              state,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load in the cycle memory actually returns the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SHL2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~opcode_supported(opcode);
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
`ifdef CTRL_BNE_EN
      BRANCHNE: begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_op           = ALUOP_SUB;
        ctrl.pc_write_cond_ne = 1'b1;
        ctrl.pc_source        = PCSRC_ALUOUT;
        ctrl.instr_done       = 1'b1;
      end
`endif
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      ORIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ORI;
      end
      IMMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register and next-state logic.
// Define CTRL_BNE_EN to add BNE support (BRANCHNE state, PCWriteCondNe output).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = STATE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; unknown encodings fall back to FETCH
  always_comb begin
    state_nxt = FETCH;
    case (state)
      IDLE:   state_nxt = FETCH;
      FETCH:  state_nxt = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.Opcode)
          R_TYPE:  state_nxt = EXEC;
          LW, SW:  state_nxt = MEMADR;
          BEQ:     state_nxt = BRANCH;
          ADDI:    state_nxt = ADDIEX;
          ORI:     state_nxt = ORIEX;
          J:       state_nxt = JUMP;
`ifdef CTRL_BNE_EN
          BNE:     state_nxt = BRANCHNE;
`endif
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: state_nxt = (bus.Opcode == LW) ? MEMRD : MEMWR;
      MEMRD:  state_nxt = bus.MemReady ? MEMWB : MEMRD;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  state_nxt = bus.MemReady ? FETCH : MEMWR;
      EXEC:   state_nxt = ALUWB;
      ALUWB:  state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
`ifdef CTRL_BNE_EN
      BRANCHNE: state_nxt = FETCH;
`endif
      ADDIEX: state_nxt = IMMWB;
      ORIEX:  state_nxt = IMMWB;
      IMMWB:  state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  multicycle_control_output_decode u_control_output_decode (
    .state     (state),
    .mem_ready (bus.MemReady),
    .opcode    (bus.Opcode),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite       = ctrl.pc_write;
  assign bus.PCWriteCond   = ctrl.pc_write_cond;
`ifdef CTRL_BNE_EN
  assign bus.PCWriteCondNe = ctrl.pc_write_cond_ne;
`endif
  assign bus.IorD          = ctrl.iord;
  assign bus.MemRead       = ctrl.mem_read;
  assign bus.MemWrite      = ctrl.mem_write;
  assign bus.IRWrite       = ctrl.ir_write;
  assign bus.MemtoReg      = ctrl.mem_to_reg;
  assign bus.RegDst        = ctrl.reg_dst;
  assign bus.RegWrite      = ctrl.reg_write;
  assign bus.ALUSrcA       = ctrl.alu_src_a;
  assign bus.ALUSrcB       = ctrl.alu_src_b;
  assign bus.PCSource      = ctrl.pc_source;
  assign bus.ALUOp         = ctrl.alu_op;
  assign bus.IllegalOp     = ctrl.illegal_op;
  assign bus.InstrDone     = ctrl.instr_done;
  assign bus.State         = STATE_WIDTH'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: each instruction is expanded into
// its expected per-cycle control trace. Honours CTRL_BNE_EN.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [18:0] obs;
  logic        obs_ne;
  assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.IllegalOp, bus.InstrDone};
`ifdef CTRL_BNE_EN
  assign obs_ne = bus.PCWriteCondNe;
`else
  assign obs_ne = 1'b0;
`endif

  function automatic logic [18:0] cv(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca,
                                     input logic [1:0] srcb, pcs, input logic [2:0] aluop,
                                     input logic ill, done);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, pcs, aluop, ill, done};
  endfunction

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [18:0] v;
    logic        ne;
    logic        rdy;
  } step_t;

  step_t       q[$];
  logic [5:0]  cur_op;

  task automatic push(input string name, input logic [3:0] st, input logic [18:0] v, input logic ne);
    step_t s;
    s.name = name; s.st = st; s.v = v; s.ne = ne; s.rdy = 1'($urandom);
    q.push_back(s);
  endtask

  // n cycles waiting on memory, then the cycle in which MemReady completes the access
  task automatic push_mem(input string name, input logic [3:0] st, input logic [18:0] vw,
                          input logic [18:0] vg, input int n);
    step_t s;
    s.name = name; s.st = st; s.ne = 1'b0;
    for (int i = 0; i < n; i++) begin
      s.v = vw; s.rdy = 1'b0; q.push_back(s);
    end
    s.v = vg; s.rdy = 1'b1; q.push_back(s);
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
`ifdef CTRL_BNE_EN
    ok = ok || (op == 6'b000101);
`endif
    return ok;
  endfunction

  // Expected trace of one instruction from the instruction-class rules
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    cur_op = op;
    push_mem("FETCH", 4'd1, cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b100,0,0),
                            cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0), fw);
    push("DECODE", 4'd2, cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,!is_legal(op),0), 1'b0);
    case (op)
      6'b000000: begin
        push("EXEC",  4'd7, cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0), 1'b0);
        push("ALUWB", 4'd8, cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,1), 1'b0);
      end
      6'b100011: begin
        push("MEMADR", 4'd3, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0), 1'b0);
        push_mem("MEMRD", 4'd4, cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0),
                                cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0), mw);
        push("MEMWB", 4'd5, cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,1), 1'b0);
      end
      6'b101011: begin
        push("MEMADR", 4'd3, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0), 1'b0);
        push_mem("MEMWR", 4'd6, cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0),
                                cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,1), mw);
      end
      6'b000100: push("BRANCH", 4'd9, cv(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b011,0,1), 1'b0);
      6'b001000: begin
        push("ADDIEX", 4'd10, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b110,0,0), 1'b0);
        push("IMMWB",  4'd12, cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,1), 1'b0);
      end
      6'b001101: begin
        push("ORIEX", 4'd11, cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b101,0,0), 1'b0);
        push("IMMWB", 4'd12, cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,1), 1'b0);
      end
      6'b000010: push("JUMP", 4'd13, cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,1), 1'b0);
`ifdef CTRL_BNE_EN
      6'b000101: push("BRANCHNE", 4'd14, cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b011,0,1), 1'b1);
`endif
      default: ;
    endcase
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/vec"},   32'(obs),       32'd0);
    check({tag, "/ne"},    32'(obs_ne),    32'd0);
    check({tag, "/state"}, 32'(bus.State), 32'd0);
  endtask

  // Replays the expected trace; abort_at >= 0 pulls reset during that step
  task automatic run(input string tag, input int abort_at);
    int idx = 0;
    while (q.size() > 0) begin
      step_t s;
      string t;
      s = q.pop_front();
      t = {tag, "/", s.name};
      @(negedge clk);
      bus.MemReady = s.rdy;
      bus.Opcode   = (s.name == "DECODE" || s.name == "MEMADR") ? cur_op : 6'($urandom);
      #1;
      check({t, "/vec"},   32'(obs),       32'(s.v));
      check({t, "/ne"},    32'(obs_ne),    32'(s.ne));
      check({t, "/state"}, 32'(bus.State), 32'(s.st));
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        check_reset_state({t, "/abort"});
        q.delete();
        repeat (2) begin
          @(negedge clk);
          bus.MemReady = 1'($urandom);
          #1;
          check_reset_state({t, "/held"});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state({t, "/release"});
      end
      idx++;
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.MemReady = 1'b1;
    bus.Opcode   = 6'd0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_state("reset");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("idle");

    build(6'b000000, 0, 0); run("rtype", -1);
    build(6'b100011, 0, 2); run("lw_wait", -1);
    build(6'b101011, 1, 0); run("sw", -1);
    build(6'b001101, 0, 0); run("ori", -1);
    build(6'b001000, 0, 0); run("addi", -1);
    build(6'b000100, 0, 0); run("beq", -1);
    build(6'b000010, 2, 0); run("j", -1);
    build(6'b000101, 0, 0); run("bne", -1);
    build(6'b111111, 0, 0); run("illegal", -1);
    build(6'b101011, 0, 3); run("sw_abort", 3);
    build(6'b000000, 0, 0); run("after_abort", -1);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int         abort_at;
      case ($urandom_range(0, 9))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b001101;
        6: op = 6'b000010;
        7: op = 6'b000101;
        default: begin
          op = 6'($urandom);
          while (is_legal(op)) op = 6'($urandom);
        end
      endcase
      build(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      abort_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run($sformatf("rnd%0d_op%02h", n, op), abort_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
